simon_seq_ctrl: RTL and testbench
=================================

# simon_seq_ctrl

Parametrised Simon game sequencer: owns the round controller, the sequence-RAM address and level counters, the flash/gap/timeout timers, a per-game lives budget and level-dependent speed-up. It sits between the keypad/RNG/sequence RAM and the background/tone generators. It supports any colour count, sequence depth and timing set through parameters.

## Interface
- NUM_COLORS, 4: number of colour channels, 2..16.
- COLOR_W, 2: colour code width; must satisfy 2^COLOR_W >= NUM_COLORS.
- ADDR_W, 5: sequence RAM address width.
- MAX_LEVEL, 31: final level; must be < 2^ADDR_W.
- GAP_TICKS, 4: ticks of dark gap before each playback flash.
- FLASH_TICKS, 8: initial flash length in ticks; must be >= 1.
- SPEEDUP_STEP, 4: flash length shrinks by 1 every SPEEDUP_STEP levels, floor 1. A value of 0 disables speed-up.
- TIMEOUT_TICKS, 64: idle ticks allowed while awaiting a key.
- LIVES, 1: mistakes allowed per game, including the fatal one; must be >= 1.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase pulse.
- enter_pressed  in  1  start/acknowledge pulse.
- key_pressed  in  1  key-down pulse.
- key_released  in  1  key-up pulse.
- key_color  in  COLOR_W  colour of the current key.
- rng_data  in  COLOR_W  free-running random value.
- mem_rd_data  in  COLOR_W  RAM read data; synchronous, valid 1 cycle after mem_raddr.
- mem_we  out  1  RAM write strobe.
- mem_waddr  out  ADDR_W  RAM write address.
- mem_wdata  out  COLOR_W  RAM write data; equals rng_data.
- mem_raddr  out  ADDR_W  RAM read address.
- level  out  ADDR_W  completed rounds in the current game.
- max_score  out  ADDR_W  best level since reset.
- lives_left  out  4  remaining lives.
- flash_en  out  1  colour lamp and tone active.
- flash_color  out  COLOR_W  colour shown while flash_en is high.
- fail_tone  out  1  error tone select.
- screen  out  2  0 = attract, 1 = play, 2 = fail, 3 = win.

## Operation
- States:
  - WAIT_SCREEN: on enter_pressed, go to GEN.
  - GEN: writes addresses 0..MAX_LEVEL, one per cycle, with mem_we=1 only when rng_data < NUM_COLORS. Out-of-range values stall without advancing mem_waddr. Leaves after writing MAX_LEVEL. Entry clears level and loads lives_left=LIVES.
  - PLAY_GAP: counts GAP_TICKS ticks, sets mem_raddr, then goes to PLAY_READ.
  - PLAY_READ: waits 1 cycle, then goes to PLAY_FLASH.
  - PLAY_FLASH: flash_en=1, flash_color=mem_rd_data (registered) for flash_len ticks. If mem_raddr==level, go to INPUT_WAIT with mem_raddr=0; otherwise increment mem_raddr and go to PLAY_GAP.
  - INPUT_WAIT: key_pressed with key_color < NUM_COLORS goes to INPUT_HOLD and latches the colour. Invalid colours are ignored. TIMEOUT_TICKS ticks with no press count as a mistake.
  - INPUT_HOLD: flash_en=1 with the latched colour. On key_released, compare against mem_rd_data.
    - Match, mem_raddr<level: increment mem_raddr and go to INPUT_WAIT.
    - Match, mem_raddr==level: go to LEVEL_UP.
    - Mismatch: treat as a mistake.
  - Mistake: decrement lives_left. If the result is 0, go to FAIL_REVEAL. Otherwise reset mem_raddr=0 and replay the same level via PLAY_GAP.
  - LEVEL_UP: if level==MAX_LEVEL, go to WIN_SCREEN with level unchanged. Otherwise increment level, set max_score=level+1 if that exceeds max_score, reset mem_raddr=0 and go to PLAY_GAP.
  - FAIL_REVEAL: flash_en=1, fail_tone=1, flash_color=expected colour for FLASH_TICKS ticks, then go to FAIL_SCREEN.
  - FAIL_SCREEN / WIN_SCREEN: on enter_pressed, go to WAIT_SCREEN.
- flash_len = max(1, FLASH_TICKS − level/SPEEDUP_STEP) using integer division. It equals FLASH_TICKS when SPEEDUP_STEP=0 and is sampled when the flash starts.
- Tick counter clears on every state entry.
- Simultaneous key_pressed and timeout expiry in the same cycle: the key wins.
- key_released without a prior hold is ignored.
- Illegal state encodings go to WAIT_SCREEN.

## Timing
- Reset values: state=WAIT_SCREEN, screen=0, and all other outputs 0, including max_score and lives_left.
  - Reset is asynchronous and takes effect mid-game.
  - Release of reset is synchronous to clk.
- All outputs are registered and change on the clk edge following the cause.
- GEN: exactly MAX_LEVEL+1 cycles when rng_data is always valid.
- Playback cost per element: GAP_TICKS + flash_len ticks + 1 read cycle.
- Comparison in INPUT_HOLD uses mem_rd_data for the current mem_raddr. The address is stable for at least 1 cycle before the compare.

## Test plan
- NUM_COLORS=4, MAX_LEVEL=3, tick every cycle, rng_data=0,1,2,3 -> RAM holds 0..3. Level 0 plays colour 0 for 8 cycles after a 4-cycle gap.
- Correct input through all levels -> level reaches 3, WIN_SCREEN with screen=3 and max_score=3.
- LIVES=2, wrong key at level 1 -> lives_left 2→1 and level 1 replays. A second wrong key -> FAIL_REVEAL shows the expected colour with fail_tone=1, then screen=2.
- NUM_COLORS=3, rng_data=3 held 5 cycles during GEN -> no write and mem_waddr frozen. Invalid key_color=3 during INPUT_WAIT is ignored.
- No key for TIMEOUT_TICKS=64 ticks -> mistake. A key arriving on the expiry cycle is accepted.
- SPEEDUP_STEP=1, FLASH_TICKS=3 -> flash lengths 3, 2, 1, 1 at levels 0–3. Reset asserted mid-flash -> immediate WAIT_SCREEN with all outputs 0.

Source files
------------

// File: rtl/simon_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simon_seq_ctrl                                                           |
// | Simon game sequencer: round FSM, sequence RAM addressing, level/lives,   |
// | flash/gap/timeout timing with level-dependent speed-up.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module simon_seq_ctrl #(
    parameter int NUM_COLORS    = 4,
    parameter int COLOR_W       = 2,
    parameter int ADDR_W        = 5,
    parameter int MAX_LEVEL     = 31,
    parameter int GAP_TICKS     = 4,
    parameter int FLASH_TICKS   = 8,
    parameter int SPEEDUP_STEP  = 4,
    parameter int TIMEOUT_TICKS = 64,
    parameter int LIVES         = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_enter_pressed,
    input  logic               i_key_pressed,
    input  logic               i_key_released,
    input  logic [COLOR_W-1:0] i_key_color,
    input  logic [COLOR_W-1:0] i_rng_data,
    input  logic [COLOR_W-1:0] i_mem_rd_data,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_waddr,
    output logic [COLOR_W-1:0] o_mem_wdata,
    output logic [ADDR_W-1:0]  o_mem_raddr,
    output logic [ADDR_W-1:0]  o_level,
    output logic [ADDR_W-1:0]  o_max_score,
    output logic [3:0]         o_lives_left,
    output logic               o_flash_en,
    output logic [COLOR_W-1:0] o_flash_color,
    output logic               o_fail_tone,
    output logic [1:0]         o_screen
);

    localparam int                 CNT_W       = 16;
    localparam logic [COLOR_W:0]   C_NUM_COLS  = (COLOR_W+1)'(NUM_COLORS);
    localparam logic [ADDR_W-1:0]  C_MAX_LEVEL = ADDR_W'(MAX_LEVEL);
    localparam logic [CNT_W-1:0]   C_GAP       = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0]   C_FLASH     = CNT_W'(FLASH_TICKS);
    localparam logic [CNT_W-1:0]   C_TIMEOUT   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [3:0]         C_LIVES     = 4'(LIVES);

    typedef enum logic [3:0] {
        S_WAIT_SCREEN = 4'd0,
        S_GEN         = 4'd1,
        S_PLAY_GAP    = 4'd2,
        S_PLAY_READ   = 4'd3,
        S_PLAY_FLASH  = 4'd4,
        S_INPUT_WAIT  = 4'd5,
        S_INPUT_HOLD  = 4'd6,
        S_LEVEL_UP    = 4'd7,
        S_FAIL_REVEAL = 4'd8,
        S_FAIL_SCREEN = 4'd9,
        S_WIN_SCREEN  = 4'd10
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_tcnt, w_tcnt_nxt, w_tcnt_inc;
    logic [CNT_W-1:0]   r_flash_len, w_flash_len_nxt, w_flash_len;
    logic [ADDR_W-1:0]  r_gen_cnt, w_gen_cnt_nxt;
    logic [COLOR_W-1:0] r_key_color, w_key_color_nxt;
    logic               r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]  r_mem_waddr, w_mem_waddr_nxt;
    logic [COLOR_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [ADDR_W-1:0]  r_mem_raddr, w_mem_raddr_nxt;
    logic [ADDR_W-1:0]  r_level, w_level_nxt, w_level_inc;
    logic [ADDR_W-1:0]  r_max_score, w_max_score_nxt;
    logic [3:0]         r_lives, w_lives_nxt;
    logic               r_flash_en, w_flash_en_nxt;
    logic [COLOR_W-1:0] r_flash_color, w_flash_color_nxt;
    logic               r_fail_tone, w_fail_tone_nxt;
    logic [1:0]         r_screen, w_screen_nxt;
    logic               w_mistake;
    logic               w_rng_valid, w_key_valid;

    assign w_tcnt_inc  = r_tcnt + CNT_W'(1);
    assign w_level_inc = r_level + ADDR_W'(1);
    assign w_rng_valid = ({1'b0, i_rng_data} < C_NUM_COLS);
    assign w_key_valid = ({1'b0, i_key_color} < C_NUM_COLS);

    // Flash length shrinks with level; the divider only exists when speed-up is enabled.
    generate
        if (SPEEDUP_STEP == 0) begin : g_no_speedup
            assign w_flash_len = C_FLASH;
        end else begin : g_speedup
            logic [CNT_W-1:0] w_dec;
            assign w_dec       = CNT_W'(32'(r_level) / SPEEDUP_STEP);
            assign w_flash_len = (w_dec >= C_FLASH) ? CNT_W'(1) : (C_FLASH - w_dec);
        end
    endgenerate

    always_comb begin
        w_state_nxt       = r_state;
        w_level_nxt       = r_level;
        w_max_score_nxt   = r_max_score;
        w_lives_nxt       = r_lives;
        w_mem_raddr_nxt   = r_mem_raddr;
        w_gen_cnt_nxt     = r_gen_cnt;
        w_mem_we_nxt      = 1'b0;
        w_mem_waddr_nxt   = r_mem_waddr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_flash_color_nxt = r_flash_color;
        w_key_color_nxt   = r_key_color;
        w_flash_len_nxt   = r_flash_len;
        w_mistake         = 1'b0;

        case (r_state)
            S_WAIT_SCREEN: begin
                if (i_enter_pressed) begin
                    w_state_nxt     = S_GEN;
                    w_level_nxt     = '0;
                    w_lives_nxt     = C_LIVES;
                    w_gen_cnt_nxt   = '0;
                    w_mem_waddr_nxt = '0;
                    w_mem_raddr_nxt = '0;
                end
            end
            S_GEN: begin
                if (w_rng_valid) begin
                    w_mem_we_nxt    = 1'b1;
                    w_mem_waddr_nxt = r_gen_cnt;
                    w_mem_wdata_nxt = i_rng_data;
                    w_gen_cnt_nxt   = r_gen_cnt + ADDR_W'(1);
                    if (r_gen_cnt == C_MAX_LEVEL) begin
                        w_state_nxt = S_PLAY_GAP;
                    end
                end
            end
            S_PLAY_GAP: begin
                if (i_tick && (w_tcnt_inc >= C_GAP)) begin
                    w_state_nxt = S_PLAY_READ;
                end
            end
            S_PLAY_READ: begin
                w_state_nxt       = S_PLAY_FLASH;
                w_flash_color_nxt = i_mem_rd_data;
                w_flash_len_nxt   = w_flash_len;
            end
            S_PLAY_FLASH: begin
                if (i_tick && (w_tcnt_inc >= r_flash_len)) begin
                    if (r_mem_raddr == r_level) begin
                        w_state_nxt     = S_INPUT_WAIT;
                        w_mem_raddr_nxt = '0;
                    end else begin
                        w_state_nxt     = S_PLAY_GAP;
                        w_mem_raddr_nxt = r_mem_raddr + ADDR_W'(1);
                    end
                end
            end
            S_INPUT_WAIT: begin
                // A valid key in the expiry cycle takes priority over the timeout.
                if (i_key_pressed && w_key_valid) begin
                    w_state_nxt       = S_INPUT_HOLD;
                    w_key_color_nxt   = i_key_color;
                    w_flash_color_nxt = i_key_color;
                end else if (i_tick && (w_tcnt_inc >= C_TIMEOUT)) begin
                    w_mistake = 1'b1;
                end
            end
            S_INPUT_HOLD: begin
                if (i_key_released) begin
                    if (r_key_color == i_mem_rd_data) begin
                        if (r_mem_raddr == r_level) begin
                            w_state_nxt = S_LEVEL_UP;
                        end else begin
                            w_state_nxt     = S_INPUT_WAIT;
                            w_mem_raddr_nxt = r_mem_raddr + ADDR_W'(1);
                        end
                    end else begin
                        w_mistake = 1'b1;
                    end
                end
            end
            S_LEVEL_UP: begin
                if (r_level == C_MAX_LEVEL) begin
                    w_state_nxt = S_WIN_SCREEN;
                end else begin
                    w_state_nxt     = S_PLAY_GAP;
                    w_level_nxt     = w_level_inc;
                    w_mem_raddr_nxt = '0;
                    if (w_level_inc > r_max_score) begin
                        w_max_score_nxt = w_level_inc;
                    end
                end
            end
            S_FAIL_REVEAL: begin
                if (i_tick && (w_tcnt_inc >= C_FLASH)) begin
                    w_state_nxt = S_FAIL_SCREEN;
                end
            end
            S_FAIL_SCREEN, S_WIN_SCREEN: begin
                if (i_enter_pressed) begin
                    w_state_nxt = S_WAIT_SCREEN;
                end
            end
            default: begin
                w_state_nxt = S_WAIT_SCREEN;
            end
        endcase

        // The read address still points at the element that was missed, so its data is the reveal colour.
        if (w_mistake) begin
            w_lives_nxt = (r_lives == 4'd0) ? 4'd0 : (r_lives - 4'd1);
            if (r_lives <= 4'd1) begin
                w_state_nxt       = S_FAIL_REVEAL;
                w_flash_color_nxt = i_mem_rd_data;
            end else begin
                w_state_nxt     = S_PLAY_GAP;
                w_mem_raddr_nxt = '0;
            end
        end

        w_flash_en_nxt  = (w_state_nxt == S_PLAY_FLASH) || (w_state_nxt == S_INPUT_HOLD) ||
                          (w_state_nxt == S_FAIL_REVEAL);
        w_fail_tone_nxt = (w_state_nxt == S_FAIL_REVEAL);
        case (w_state_nxt)
            S_WAIT_SCREEN: w_screen_nxt = 2'd0;
            S_FAIL_SCREEN: w_screen_nxt = 2'd2;
            S_WIN_SCREEN:  w_screen_nxt = 2'd3;
            default:       w_screen_nxt = 2'd1;
        endcase

        if (w_state_nxt != r_state) begin
            w_tcnt_nxt = '0;
        end else if (i_tick) begin
            w_tcnt_nxt = w_tcnt_inc;
        end else begin
            w_tcnt_nxt = r_tcnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_WAIT_SCREEN;
            r_tcnt        <= '0;
            r_flash_len   <= '0;
            r_gen_cnt     <= '0;
            r_key_color   <= '0;
            r_mem_we      <= 1'b0;
            r_mem_waddr   <= '0;
            r_mem_wdata   <= '0;
            r_mem_raddr   <= '0;
            r_level       <= '0;
            r_max_score   <= '0;
            r_lives       <= '0;
            r_flash_en    <= 1'b0;
            r_flash_color <= '0;
            r_fail_tone   <= 1'b0;
            r_screen      <= 2'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_flash_len   <= w_flash_len_nxt;
            r_gen_cnt     <= w_gen_cnt_nxt;
            r_key_color   <= w_key_color_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_waddr   <= w_mem_waddr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_mem_raddr   <= w_mem_raddr_nxt;
            r_level       <= w_level_nxt;
            r_max_score   <= w_max_score_nxt;
            r_lives       <= w_lives_nxt;
            r_flash_en    <= w_flash_en_nxt;
            r_flash_color <= w_flash_color_nxt;
            r_fail_tone   <= w_fail_tone_nxt;
            r_screen      <= w_screen_nxt;
        end
    end

    assign o_mem_we      = r_mem_we;
    assign o_mem_waddr   = r_mem_waddr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_mem_raddr   = r_mem_raddr;
    assign o_level       = r_level;
    assign o_max_score   = r_max_score;
    assign o_lives_left  = r_lives;
    assign o_flash_en    = r_flash_en;
    assign o_flash_color = r_flash_color;
    assign o_fail_tone   = r_fail_tone;
    assign o_screen      = r_screen;

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_simon_seq_ctrl                                                        |
// | Self-checking bench: three games against a game-rule reference model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_simon_seq_ctrl;

    localparam int NUM_COLORS    = 3;
    localparam int COLOR_W       = 2;
    localparam int ADDR_W        = 5;
    localparam int MAX_LEVEL     = 3;
    localparam int GAP_TICKS     = 4;
    localparam int FLASH_TICKS   = 3;
    localparam int SPEEDUP_STEP  = 1;
    localparam int TIMEOUT_TICKS = 64;
    localparam int LIVES         = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_tick, i_enter_pressed, i_key_pressed, i_key_released;
    logic [COLOR_W-1:0] i_key_color, i_rng_data, r_rd_data;
    logic               o_mem_we, o_flash_en, o_fail_tone;
    logic [ADDR_W-1:0]  o_mem_waddr, o_mem_raddr, o_level, o_max_score;
    logic [COLOR_W-1:0] o_mem_wdata, o_flash_color;
    logic [3:0]         o_lives_left;
    logic [1:0]         o_screen;

    logic [COLOR_W-1:0] ram [0:(1<<ADDR_W)-1];
    int                 exp_col [0:MAX_LEVEL];
    int                 checks   = 0;
    int                 failures = 0;

    simon_seq_ctrl #(
        .NUM_COLORS(NUM_COLORS), .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .MAX_LEVEL(MAX_LEVEL),
        .GAP_TICKS(GAP_TICKS), .FLASH_TICKS(FLASH_TICKS), .SPEEDUP_STEP(SPEEDUP_STEP),
        .TIMEOUT_TICKS(TIMEOUT_TICKS), .LIVES(LIVES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_tick(i_tick), .i_enter_pressed(i_enter_pressed),
        .i_key_pressed(i_key_pressed), .i_key_released(i_key_released),
        .i_key_color(i_key_color), .i_rng_data(i_rng_data), .i_mem_rd_data(r_rd_data),
        .o_mem_we(o_mem_we), .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata),
        .o_mem_raddr(o_mem_raddr), .o_level(o_level), .o_max_score(o_max_score),
        .o_lives_left(o_lives_left), .o_flash_en(o_flash_en), .o_flash_color(o_flash_color),
        .o_fail_tone(o_fail_tone), .o_screen(o_screen)
    );

    always #5 clk = ~clk;

    // Synchronous-read sequence RAM
    always @(posedge clk) begin
        if (o_mem_we) ram[o_mem_waddr] <= o_mem_wdata;
        r_rd_data <= ram[o_mem_raddr];
    end

    function automatic int flen(input int lvl);
        int v;
        if (SPEEDUP_STEP == 0) return FLASH_TICKS;
        v = FLASH_TICKS - lvl / SPEEDUP_STEP;
        return (v < 1) ? 1 : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic gen_game(input int stall);
        int n, r, cyc;
        @(negedge clk); i_enter_pressed = 1'b1;
        @(negedge clk); i_enter_pressed = 1'b0;
        chk("gen_lives", o_lives_left, LIVES);
        chk("gen_level", o_level, 0);
        chk("gen_screen", o_screen, 1);
        n = 0; cyc = 0;
        while (n <= MAX_LEVEL && cyc < 200) begin
            r = (cyc < stall) ? 3 : int'($urandom_range(0, 3));
            i_rng_data = COLOR_W'(r);
            @(negedge clk);
            if (r < NUM_COLORS) begin
                chk("gen_we", o_mem_we, 1);
                chk("gen_waddr", o_mem_waddr, n);
                chk("gen_wdata", o_mem_wdata, r);
                exp_col[n] = r;
                n++;
            end else begin
                chk("gen_stall_we", o_mem_we, 0);
                chk("gen_stall_waddr", o_mem_waddr, (n == 0) ? 0 : n - 1);
            end
            cyc++;
        end
        chk("gen_count", n, MAX_LEVEL + 1);
    endtask

    task automatic watch_playback(input int lvl);
        int d, h;
        for (int i = 0; i <= lvl; i++) begin
            d = 0;
            while (o_flash_en !== 1'b1 && d < 300) begin
                @(negedge clk); d++;
            end
            chk("flash_start", o_flash_en, 1);
            if (i == 0) chk("play_level", o_level, lvl);
            else chk("gap_len", d, GAP_TICKS + 1);
            chk("flash_color", o_flash_color, exp_col[i]);
            chk("play_fail_tone", o_fail_tone, 0);
            h = 0;
            while (o_flash_en === 1'b1 && h < 300) begin
                h++; @(negedge clk);
            end
            chk("flash_len", h, flen(lvl));
        end
    endtask

    task automatic press(input int c);
        i_key_color   = COLOR_W'(c);
        i_key_pressed = 1'b1;
        @(negedge clk); i_key_pressed = 1'b0;
        chk("hold_lamp", o_flash_en, 1);
        chk("hold_color", o_flash_color, c);
        repeat (2) @(negedge clk);
        i_key_released = 1'b1;
        @(negedge clk); i_key_released = 1'b0;
    endtask

    initial begin
        int h;
        rst_n = 1'b0; i_tick = 1'b1; i_enter_pressed = 1'b0; i_key_pressed = 1'b0;
        i_key_released = 1'b0; i_key_color = '0; i_rng_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_screen", o_screen, 0);
        chk("rst_lives", o_lives_left, 0);
        chk("rst_max", o_max_score, 0);
        chk("rst_flash", o_flash_en, 0);
        chk("rst_we", o_mem_we, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_screen", o_screen, 0);

        // Game 1: stalled generation, invalid key, one mistake, then a win
        gen_game(5);
        watch_playback(0);
        i_key_color = 2'd3; i_key_pressed = 1'b1;
        @(negedge clk); i_key_pressed = 1'b0;
        chk("invalid_key_ignored", o_flash_en, 0);
        i_key_released = 1'b1;
        @(negedge clk); i_key_released = 1'b0;
        chk("stray_release_lamp", o_flash_en, 0);
        chk("stray_release_lives", o_lives_left, LIVES);
        press(exp_col[0]);
        watch_playback(1);
        press((exp_col[0] + 1) % NUM_COLORS);
        chk("mistake_lives", o_lives_left, LIVES - 1);
        chk("mistake_screen", o_screen, 1);
        watch_playback(1);
        for (int l = 1; l <= MAX_LEVEL; l++) begin
            for (int i = 0; i <= l; i++) press(exp_col[i]);
            if (l < MAX_LEVEL) watch_playback(l + 1);
        end
        @(negedge clk);
        chk("win_screen", o_screen, 3);
        chk("win_level", o_level, MAX_LEVEL);
        chk("win_max", o_max_score, MAX_LEVEL);
        @(negedge clk); i_enter_pressed = 1'b1;
        @(negedge clk); i_enter_pressed = 1'b0;
        chk("back_to_attract", o_screen, 0);

        // Game 2: timeout mistake, key on expiry cycle, fatal mistake
        gen_game(0);
        watch_playback(0);
        repeat (63) @(negedge clk);
        chk("pre_timeout_lives", o_lives_left, LIVES);
        @(negedge clk);
        chk("timeout_lives", o_lives_left, LIVES - 1);
        watch_playback(0);
        repeat (63) @(negedge clk);
        press(exp_col[0]);
        watch_playback(1);
        press((exp_col[0] + 2) % NUM_COLORS);
        chk("reveal_lamp", o_flash_en, 1);
        chk("reveal_tone", o_fail_tone, 1);
        chk("reveal_color", o_flash_color, exp_col[0]);
        chk("reveal_lives", o_lives_left, 0);
        h = 0;
        while (o_flash_en === 1'b1 && h < 100) begin
            h++; @(negedge clk);
        end
        chk("reveal_len", h, FLASH_TICKS);
        chk("fail_screen", o_screen, 2);
        chk("fail_tone_off", o_fail_tone, 0);
        chk("fail_max_kept", o_max_score, MAX_LEVEL);
        i_enter_pressed = 1'b1;
        @(negedge clk); i_enter_pressed = 1'b0;
        chk("fail_to_attract", o_screen, 0);

        // Game 3: asynchronous reset in the middle of a flash
        gen_game(0);
        h = 0;
        while (o_flash_en !== 1'b1 && h < 100) begin
            @(negedge clk); h++;
        end
        chk("pre_reset_flash", o_flash_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_screen", o_screen, 0);
        chk("async_rst_flash", o_flash_en, 0);
        chk("async_rst_max", o_max_score, 0);
        chk("async_rst_lives", o_lives_left, 0);
        chk("async_rst_raddr", o_mem_raddr, 0);
        chk("async_rst_color", o_flash_color, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_screen", o_screen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
